// File: rtl/conv_pkg.sv
// Shared convolution datapath types: pixel width, default frame geometry and the
// 3-pixel column window consumed by cal_multi_3INT8 and downstream stages.
package conv_pkg;

   localparam int unsigned DATA_W    = 8;
   localparam int unsigned IMG_W_DEF = 480;
   localparam int unsigned IMG_H_DEF = 480;

   typedef logic signed [DATA_W-1:0] pix_t;

   // [0] = row r-2 (top), [1] = row r-1, [2] = row r
   typedef pix_t [2:0] col3_t;

endpackage

// File: rtl/conv_line_ram.sv
// Single-port line memory: combinational read of the addressed word, synchronous write,
// so a read and a write to the same address in one cycle return the old word.
module conv_line_ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 480,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   assign rdata = mem[addr];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/conv_line_buffer_3row.sv
// Raster pixel stream to 3-row vertical column feeder for the 3x3 INT8 MAC.
// Build option LINEBUF_TOP_PAD_EN: emit rows 0/1 too, with missing rows zero-padded.
module conv_line_buffer_3row #(
   parameter int unsigned DATA_W = conv_pkg::DATA_W,
   parameter int unsigned IMG_W  = conv_pkg::IMG_W_DEF,
   parameter int unsigned IMG_H  = conv_pkg::IMG_H_DEF,
   parameter int unsigned COL_W  = $clog2(IMG_W),
   parameter int unsigned ROW_W  = $clog2(IMG_H)
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     valid_in,
   input  logic signed [DATA_W-1:0] din,
   output logic                     valid_out,
   output logic signed [DATA_W-1:0] dout_1,
   output logic signed [DATA_W-1:0] dout_2,
   output logic signed [DATA_W-1:0] dout_3,
   output logic                     sol_out,
   output logic                     eol_out,
   output logic                     eof_out
);

   logic [COL_W-1:0]  col_cnt;
   logic [ROW_W-1:0]  row_cnt;
   logic [DATA_W-1:0] line0_rd;
   logic [DATA_W-1:0] line1_rd;
   logic [DATA_W-1:0] top_pix;
   logic [DATA_W-1:0] mid_pix;
   logic              last_col;
   logic              last_row;
   logic              emit;

   // line0 holds row r-1, line1 holds row r-2; line1 is refilled from line0's old word
   conv_line_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W),
      .ADDR_W (COL_W)
   ) u_line0 (
      .clk   (clk),
      .we    (valid_in),
      .addr  (col_cnt),
      .wdata (din),
      .rdata (line0_rd)
   );

   conv_line_ram #(
      .DATA_W (DATA_W),
      .DEPTH  (IMG_W),
      .ADDR_W (COL_W)
   ) u_line1 (
      .clk   (clk),
      .we    (valid_in),
      .addr  (col_cnt),
      .wdata (line0_rd),
      .rdata (line1_rd)
   );

   always_comb begin
      last_col = (col_cnt == COL_W'(IMG_W - 1));
      last_row = (row_cnt == ROW_W'(IMG_H - 1));
`ifdef LINEBUF_TOP_PAD_EN
      // Padding keyed on row_cnt so stale line memory after a reset never leaks out
      emit    = 1'b1;
      top_pix = (row_cnt < ROW_W'(2)) ? '0 : line1_rd;
      mid_pix = (row_cnt == '0) ? '0 : line0_rd;
`else
      emit    = (row_cnt >= ROW_W'(2));
      top_pix = line1_rd;
      mid_pix = line0_rd;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         col_cnt   <= '0;
         row_cnt   <= '0;
         valid_out <= 1'b0;
         sol_out   <= 1'b0;
         eol_out   <= 1'b0;
         eof_out   <= 1'b0;
         dout_1    <= '0;
         dout_2    <= '0;
         dout_3    <= '0;
      end else begin
         valid_out <= valid_in & emit;
         sol_out   <= valid_in & emit & (col_cnt == '0);
         eol_out   <= valid_in & emit & last_col;
         eof_out   <= valid_in & emit & last_col & last_row;
         if (valid_in && emit) begin
            dout_1 <= top_pix;
            dout_2 <= mid_pix;
            dout_3 <= din;
         end
         if (valid_in) begin
            if (last_col) begin
               col_cnt <= '0;
               row_cnt <= last_row ? '0 : row_cnt + ROW_W'(1);
            end else begin
               col_cnt <= col_cnt + COL_W'(1);
            end
         end
      end
   end

endmodule
